// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, requests to send,
// shifts a byte + odd parity + stop on device clock falling edges, then checks the ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       clk_ps2,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          dat_s1_q, dat_s2_q;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          fall;
  logic [8:0]    frame;

  assign fall  = clk_s3_q & ~clk_s2_q;
  assign frame = {par_q, data_q};

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_d      = par_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          data_d     = tx_data;
          par_d      = ~^tx_data;
          inh_cnt_d  = '0;
          to_cnt_d   = '0;
          edge_cnt_d = '0;
          clk_oe_d   = 1'b1;
          data_oe_d  = 1'b0;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // start bit goes low one cycle before the clock is released
        if (inh_cnt_q == INH_PRE) data_oe_d = 1'b1;
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = REQ;
        end
      end
      default: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (to_cnt_q == TO_LAST) begin
          error_d   = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end else begin
          case (state_q)
            REQ, SHIFT: begin
              if (fall) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
                if (edge_cnt_q == 4'd9) begin
                  data_oe_d = 1'b0;
                  state_d   = ACK;
                end else begin
                  data_oe_d = ~frame[edge_cnt_q];
                  state_d   = SHIFT;
                end
              end
            end
            ACK: begin
              if (fall) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
                if (dat_s2_q) begin
                  error_d = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = RELEASE;
                end
              end
            end
            RELEASE: begin
              if (clk_s2_q && dat_s2_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      par_q      <= 1'b0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_q      <= par_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clk_s1_q   <= clk_ps2;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model plus a result scoreboard
// (done / error expected per transfer, popped when the DUT pulses one).
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 2500;
  localparam int TO  = 3000;
  localparam int H   = 40;     // device clock half period in clk cycles
  localparam int RES_DONE = 2; // {done,error}
  localparam int RES_ERR  = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       clk_ps2, ps2_data_in;
  logic       done_p = 1'b0, err_p = 1'b0;
  int         n_chk = 0, n_pass = 0;
  int         exp_q[$];

  assign clk_ps2     = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  always #20 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error), .clk_ps2(clk_ps2),
    .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (done || error) begin
      if (exp_q.size() == 0) chk("unexpected_result", int'({done, error}), 0);
      else chk("result", int'({done, error}), exp_q.pop_front());
    end
    if (done_p || err_p) chk("pulse_1cyc", int'({done & done_p, error & err_p}), 0);
    done_p <= done;
    err_p  <= error;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk); tx_data = b; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    chk("busy_rise", int'(busy), 1);
  endtask

  // Device side of one frame; stop>0 leaves the clock held low at that edge.
  task automatic dev_xfer(input logic [7:0] b, input logic nack, input int stop);
    logic [10:1] fr;
    logic        last_doe;
    int          n;
    fr = {1'b1, ~^b, b};
    n = 0;
    while (!ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    chk("inh_seen", int'(ps2_clk_oe), 1);
    chk("inh_doe_lo", int'(ps2_data_oe), 0);
    n = 0; last_doe = 1'b0;
    while (ps2_clk_oe && n < INH + 100) begin
      last_doe = ps2_data_oe; n++; @(negedge clk);
    end
    chk("inh_len", n, INH);
    chk("start_last_inh", int'(last_doe), 1);
    chk("req_doe", int'(ps2_data_oe), 1);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_data = nack;
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      if (k == stop) return;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) chk($sformatf("bit%0d", k), int'(~ps2_data_oe & dev_data), int'(fr[k]));
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2 * TO) begin @(negedge clk); n++; end
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    reset = 1'b0;

    exp_q.push_back(RES_DONE);
    start_tx(8'hED); dev_xfer(8'hED, 1'b0, 0); wait_idle("ed_idle");

    exp_q.push_back(RES_DONE);
    start_tx(8'h01); dev_xfer(8'h01, 1'b0, 0); wait_idle("x01_idle");

    exp_q.push_back(RES_ERR);
    start_tx(8'hA5); dev_xfer(8'hA5, 1'b1, 0); wait_idle("nack_idle");
    chk("nack_clk_oe", int'(ps2_clk_oe), 0);
    chk("nack_data_oe", int'(ps2_data_oe), 0);

    // device stays silent after the clock is released
    exp_q.push_back(RES_ERR);
    start_tx(8'h3C);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin @(negedge clk); n++; end
    n = 0;
    while (!error && n < TO + 100) begin @(negedge clk); n++; end
    chk("timeout_cycles", n, TO);
    chk("to_clk_oe", int'(ps2_clk_oe), 0);
    chk("to_data_oe", int'(ps2_data_oe), 0);
    @(negedge clk);
    chk("to_idle", int'(busy), 0);

    // second request while busy, then reset during edge 5
    start_tx(8'h0F);
    fork
      dev_xfer(8'h0F, 1'b0, 5);
      begin
        repeat (20) @(negedge clk);
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk); tx_start = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    chk("abort_doe_pre", int'(ps2_data_oe), 1);
    #5 reset = 1'b1;
    #1;
    chk("abort_clk_oe", int'(ps2_clk_oe), 0);
    chk("abort_data_oe", int'(ps2_data_oe), 0);
    chk("abort_busy", int'(busy), 0);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (200) begin @(negedge clk); if (busy) n++; end
    chk("no_queued", n, 0);

    exp_q.push_back(RES_DONE);
    start_tx(8'hF4); dev_xfer(8'hF4, 1'b0, 0); wait_idle("f4_idle");
    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
